rx_iq_buffer: RTL and testbench

Single-clock FIFO between the DDC decimator output and the STM32 bus interface. It stores RX1/RX2 I/Q sample sets as the decimator produces them and presents the oldest set first-word-fall-through on `RX1_I`…`RX2_Q`. It advances on each `IQ_RX_READ_CLK` pulse from the interface and reports `in_empty`, fill level and sticky overrun/underrun flags.

---
 rtl/rx_iq_buffer.sv | 125 ++++++++++++
 tb/tb_rx_iq_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_iq_buffer.sv
// rx_iq_buffer: single-clock first-word-fall-through FIFO holding RX1/RX2 I/Q
// sample sets between the decimator and the bus interface. The head entry is
// presented on registered outputs. Pops come from rising edges of a read clock
// that is sampled in this clock domain.
module rx_iq_buffer #(
  parameter int DEPTH    = 16,
  parameter int IQ_WIDTH = 24
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic signed [IQ_WIDTH-1:0] rx1_i_in,
  input  logic signed [IQ_WIDTH-1:0] rx1_q_in,
  input  logic signed [IQ_WIDTH-1:0] rx2_i_in,
  input  logic signed [IQ_WIDTH-1:0] rx2_q_in,
  input  logic                       iq_valid,
  input  logic                       rx2_enable,
  input  logic                       IQ_RX_READ_REQ,
  input  logic                       IQ_RX_READ_CLK,
  input  logic                       clear_flags,
  output logic signed [IQ_WIDTH-1:0] RX1_I,
  output logic signed [IQ_WIDTH-1:0] RX1_Q,
  output logic signed [IQ_WIDTH-1:0] RX2_I,
  output logic signed [IQ_WIDTH-1:0] RX2_Q,
  output logic                       in_empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overrun,
  output logic                       underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 4 * IQ_WIDTH;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic [EW-1:0] head_q, head_d;
  logic          overrun_q, overrun_d;
  logic          underrun_q, underrun_d;
  logic          rd_clk_q;

  logic          pop_req;
  logic          pop_ok;
  logic          wr_ok;
  logic          is_empty;
  logic          is_full;
  logic [EW-1:0] wr_data;

  // Decode pop/write acceptance and compute every next-state value.
  always_comb begin
    is_empty = (level_q == '0);
    is_full  = (level_q == LVL_FULL);
    pop_req  = IQ_RX_READ_REQ & IQ_RX_READ_CLK & ~rd_clk_q;
    // A pop on an empty FIFO is ignored even if a write lands in the same cycle.
    pop_ok   = pop_req & ~is_empty;
    // When full, a simultaneous pop frees the slot the write needs.
    wr_ok    = iq_valid & (~is_full | pop_req);
    wr_data  = {rx1_i_in, rx1_q_in,
                rx2_enable ? rx2_i_in : '0,
                rx2_enable ? rx2_q_in : '0};

    wp_d    = wp_q + AW'(wr_ok);
    rp_d    = rp_q + AW'(pop_ok);
    level_d = level_q + (AW+1)'(wr_ok) - (AW+1)'(pop_ok);
    empty_d = (level_d == '0);
    full_d  = (level_d == LVL_FULL);

    // Head follows the next read pointer; a write into an empty FIFO is
    // forwarded directly since the array is not updated until this edge.
    head_d = head_q;
    if (level_d != '0) begin
      if (wr_ok && (wp_q == rp_d)) head_d = wr_data;
      else                         head_d = mem_q[rp_d];
    end

    overrun_d  = (overrun_q  & ~clear_flags) | (iq_valid & is_full & ~pop_req);
    underrun_d = (underrun_q & ~clear_flags) | (pop_req & is_empty);
  end

  // Control, flag and head registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      wp_q       <= '0;
      rp_q       <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      head_q     <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      rd_clk_q   <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      head_q     <= head_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      rd_clk_q   <= IQ_RX_READ_CLK;
    end
  end

  // Sample storage; contents are don't-care after reset so it carries none.
  always_ff @(posedge clk_in) begin
    if (!reset && wr_ok) mem_q[wp_q] <= wr_data;
  end

  assign RX1_I    = head_q[EW-1 -: IQ_WIDTH];
  assign RX1_Q    = head_q[EW-IQ_WIDTH-1 -: IQ_WIDTH];
  assign RX2_I    = head_q[2*IQ_WIDTH-1 -: IQ_WIDTH];
  assign RX2_Q    = head_q[IQ_WIDTH-1:0];
  assign in_empty = empty_q;
  assign full     = full_q;
  assign level    = level_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_rx_iq_buffer.sv
// Directed bench for rx_iq_buffer (DEPTH=16, IQ_WIDTH=24).
module tb_rx_iq_buffer;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [23:0] rx1_i_in, rx1_q_in, rx2_i_in, rx2_q_in;
  logic        iq_valid, rx2_enable, IQ_RX_READ_REQ, IQ_RX_READ_CLK, clear_flags;
  logic [23:0] RX1_I, RX1_Q, RX2_I, RX2_Q;
  logic        in_empty, full, overrun, underrun;
  logic [4:0]  level;

  int total = 0;
  int bad   = 0;
  int q[$];

  rx_iq_buffer #(.DEPTH(16), .IQ_WIDTH(24)) dut (
    .clk_in(clk_in), .reset(reset),
    .rx1_i_in(rx1_i_in), .rx1_q_in(rx1_q_in), .rx2_i_in(rx2_i_in), .rx2_q_in(rx2_q_in),
    .iq_valid(iq_valid), .rx2_enable(rx2_enable),
    .IQ_RX_READ_REQ(IQ_RX_READ_REQ), .IQ_RX_READ_CLK(IQ_RX_READ_CLK),
    .clear_flags(clear_flags),
    .RX1_I(RX1_I), .RX1_Q(RX1_Q), .RX2_I(RX2_I), .RX2_Q(RX2_Q),
    .in_empty(in_empty), .full(full), .level(level),
    .overrun(overrun), .underrun(underrun)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [23:0] a, input logic [23:0] b,
                    input logic [23:0] c, input logic [23:0] d, input logic en);
    rx1_i_in = a; rx1_q_in = b; rx2_i_in = c; rx2_q_in = d; rx2_enable = en;
    iq_valid = 1'b1;
    step();
    iq_valid = 1'b0;
  endtask

  task automatic pop();
    IQ_RX_READ_REQ = 1'b1;
    IQ_RX_READ_CLK = 1'b1;
    step();
    IQ_RX_READ_CLK = 1'b0;
    step();
  endtask

  task automatic clr();
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
  endtask

  initial begin
    reset = 1'b1; iq_valid = 1'b0; rx2_enable = 1'b0;
    IQ_RX_READ_REQ = 1'b0; IQ_RX_READ_CLK = 1'b0; clear_flags = 1'b0;
    rx1_i_in = '0; rx1_q_in = '0; rx2_i_in = '0; rx2_q_in = '0;
    step(); step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_empty", in_empty, 1);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_rx1i", RX1_I, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_udr", underrun, 0);

    // Single write with RX2 masked, then single pop
    wr(24'h123456, 24'hFEDCBA, 24'h111111, 24'h222222, 1'b0);
    chk("w1_rx1i", RX1_I, 32'h123456);
    chk("w1_rx1q", RX1_Q, 32'hFEDCBA);
    chk("w1_rx2i", RX2_I, 0);
    chk("w1_rx2q", RX2_Q, 0);
    chk("w1_empty", in_empty, 0);
    chk("w1_level", level, 1);
    pop();
    chk("p1_empty", in_empty, 1);
    chk("p1_rx1i_hold", RX1_I, 32'h123456);
    chk("p1_udr", underrun, 0);

    // Fill with 17 sets, last one overflows
    for (int k = 1; k <= 17; k++)
      wr(24'(k), 24'(k + 100), 24'(k + 200), 24'(k + 300), 1'b1);
    chk("fill_full", full, 1);
    chk("fill_ovr", overrun, 1);
    chk("fill_level", level, 16);
    chk("fill_head", RX1_I, 1);
    clr();
    chk("clr_ovr", overrun, 0);
    for (int k = 1; k <= 16; k++) begin
      chk("drain_rx1i", RX1_I, 32'(k));
      chk("drain_rx2q", RX2_Q, 32'(k + 300));
      pop();
    end
    chk("drain_empty", in_empty, 1);
    chk("drain_level", level, 0);
    chk("drain_hold", RX1_I, 16);
    chk("drain_udr", underrun, 0);

    // Pop while empty sets underrun; clear in the same cycle loses to the set
    IQ_RX_READ_REQ = 1'b1; IQ_RX_READ_CLK = 1'b1; clear_flags = 1'b1;
    step();
    IQ_RX_READ_CLK = 1'b0; clear_flags = 1'b0;
    step();
    chk("udr_set_wins", underrun, 1);
    chk("udr_level", level, 0);
    clr();
    chk("udr_clr", underrun, 0);

    // Full with simultaneous write and pop
    for (int k = 0; k < 16; k++)
      wr(24'(50 + k), 24'h0, 24'h0, 24'h0, 1'b1);
    chk("full2_full", full, 1);
    rx1_i_in = 24'd99; iq_valid = 1'b1;
    IQ_RX_READ_REQ = 1'b1; IQ_RX_READ_CLK = 1'b1;
    step();
    iq_valid = 1'b0; IQ_RX_READ_CLK = 1'b0;
    chk("fwp_level", level, 16);
    chk("fwp_ovr", overrun, 0);
    chk("fwp_full", full, 1);
    chk("fwp_head", RX1_I, 51);
    step();
    for (int k = 0; k < 16; k++) begin
      chk("fwp_drain", RX1_I, (k < 15) ? 32'(51 + k) : 32'd99);
      pop();
    end
    chk("fwp_empty", in_empty, 1);

    // Empty with simultaneous write and pop
    rx1_i_in = 24'h000777; iq_valid = 1'b1;
    IQ_RX_READ_REQ = 1'b1; IQ_RX_READ_CLK = 1'b1;
    step();
    iq_valid = 1'b0; IQ_RX_READ_CLK = 1'b0;
    chk("ewp_level", level, 1);
    chk("ewp_udr", underrun, 1);
    chk("ewp_head", RX1_I, 32'h777);
    chk("ewp_empty", in_empty, 0);
    step();
    clr();
    pop();
    chk("ewp_drain", level, 0);

    // Held read clock produces exactly one pop
    wr(24'd10, 24'h0, 24'h0, 24'h0, 1'b1);
    wr(24'd11, 24'h0, 24'h0, 24'h0, 1'b1);
    wr(24'd12, 24'h0, 24'h0, 24'h0, 1'b1);
    IQ_RX_READ_REQ = 1'b1; IQ_RX_READ_CLK = 1'b1;
    repeat (5) step();
    IQ_RX_READ_CLK = 1'b0;
    step();
    chk("held_level", level, 2);
    chk("held_head", RX1_I, 11);
    IQ_RX_READ_REQ = 1'b0; IQ_RX_READ_CLK = 1'b1;
    step();
    IQ_RX_READ_CLK = 1'b0;
    step();
    chk("noreq_level", level, 2);
    chk("noreq_head", RX1_I, 11);

    // Interleaved writes and pops across pointer wrap against a queue model
    q.push_back(11);
    q.push_back(12);
    for (int i = 0; i < 40; i++) begin
      wr(24'(32'h1000 + i), 24'(i), 24'h0, 24'h0, 1'b1);
      q.push_back(32'h1000 + i);
      chk("wrap_head", RX1_I, 32'(q[0]));
      void'(q.pop_front());
      pop();
    end
    chk("wrap_level", level, 2);
    chk("wrap_final_head", RX1_I, 32'(q[0]));

    // Reset mid-burst discards everything
    wr(24'h000201, 24'h0, 24'h0, 24'h0, 1'b1);
    wr(24'h000202, 24'h0, 24'h0, 24'h0, 1'b1);
    wr(24'h000203, 24'h0, 24'h0, 24'h0, 1'b1);
    chk("pre_rst_level", level, 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", in_empty, 1);
    chk("mid_rst_rx1i", RX1_I, 0);
    wr(24'h000AAA, 24'h0, 24'h0, 24'h0, 1'b0);
    chk("post_rst_head", RX1_I, 32'hAAA);
    chk("post_rst_level", level, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
